// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: word width, PC vectors
// and the program-counter sequencer state encoding.
package mips_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
   localparam logic [WORD_W-1:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

   typedef enum logic [1:0] {
      PCS_RUN    = 2'd0,
      PCS_DELAY  = 2'd1,
      PCS_HALTED = 2'd2
   } pcs_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, one-instruction branch delay
// slot, halt on redirect to HALT_ADDR and sticky misaligned-target detection.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [WORD_W-1:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              instr_done,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] tgt_addr,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4,
   output logic              in_delay_slot,
   output logic              active,
   output logic              misaligned
);

   pcs_state_t        state_reg, state_next;
   logic [WORD_W-1:0] pc_reg, pc_next;
   logic [WORD_W-1:0] held_tgt_reg, held_tgt_next;
   logic              active_reg, active_next;
   logic              misaligned_reg, misaligned_next;
   logic              advance;

   assign advance  = clk_enable && instr_done;
   assign pc_plus4 = pc_reg + WORD_W'(4);

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      held_tgt_next   = held_tgt_reg;
      active_next     = active_reg;
      misaligned_next = misaligned_reg;
      if (advance) begin
         case (state_reg)
            PCS_RUN: begin
               pc_next = pc_plus4;
               if (branch_taken) begin
                  held_tgt_next = tgt_addr;
                  state_next    = PCS_DELAY;
               end
            end
            PCS_DELAY: begin
               // Delay-slot instruction retires; branch inputs are ignored here.
               pc_next = held_tgt_reg;
               if (held_tgt_reg == HALT_ADDR) begin
                  state_next  = PCS_HALTED;
                  active_next = 1'b0;
               end else if (held_tgt_reg[1:0] != 2'b00) begin
                  state_next      = PCS_HALTED;
                  active_next     = 1'b0;
                  misaligned_next = 1'b1;
               end else begin
                  state_next = PCS_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= PCS_RUN;
         pc_reg         <= RESET_VECTOR;
         held_tgt_reg   <= '0;
         active_reg     <= 1'b1;
         misaligned_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         held_tgt_reg   <= held_tgt_next;
         active_reg     <= active_next;
         misaligned_reg <= misaligned_next;
      end
   end

   assign pc            = pc_reg;
   assign active        = active_reg;
   assign misaligned    = misaligned_reg;
   assign in_delay_slot = (state_reg == PCS_DELAY);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table for straight-line and
// simple branch flow, plus hand-written stall, wrap, halt and reset sequences.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, clk_enable, instr_done, branch_taken;
   logic [31:0] tgt_addr;
   logic [31:0] pc, pc_plus4;
   logic        in_delay_slot, active, misaligned;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        ce;
      logic        id;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic        exp_act;
      logic        exp_mis;
      logic        exp_ds;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[8];

   pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .clk_enable   (clk_enable),
      .instr_done   (instr_done),
      .branch_taken (branch_taken),
      .tgt_addr     (tgt_addr),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .in_delay_slot(in_delay_slot),
      .active       (active),
      .misaligned   (misaligned)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, compare after the edge.
   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      reset        = v.rst;
      clk_enable   = v.ce;
      instr_done   = v.id;
      branch_taken = v.br;
      tgt_addr     = v.tgt;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, " pc"}, pc, e.exp_pc);
      check({tag, " pc_plus4"}, pc_plus4, e.exp_pc + 32'd4);
      check({tag, " active"}, {31'd0, active}, {31'd0, e.exp_act});
      check({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, e.exp_mis});
      check({tag, " in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, e.exp_ds});
      $display("%-10s rst=%b ce=%b id=%b br=%b tgt=%h -> pc=%h act=%b mis=%b ds=%b",
               tag, v.rst, v.ce, v.id, v.br, v.tgt, pc, active, misaligned, in_delay_slot);
   endtask

   task automatic step(input string tag, input logic rst, input logic ce, input logic id,
                       input logic br, input logic [31:0] tgt, input logic [31:0] epc,
                       input logic eact, input logic emis, input logic eds);
      vec_t v;
      v = '{rst, ce, id, br, tgt, epc, eact, emis, eds};
      apply(tag, v);
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b0; instr_done = 1'b0;
      branch_taken = 1'b0; tgt_addr = '0;

      //        rst   ce    id    br    tgt            pc             act   mis   ds
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00004, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00008, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC0000C, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00010, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hBFC00100, 32'hBFC00014, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00100, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'hBFC00100, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 8; i++) apply($sformatf("tbl%0d", i), tbl[i]);

      // Stalls while in the delay slot; branch inputs in DELAY are ignored.
      step("stall_br", 0, 1, 1, 1, 32'hBFC00200, 32'hBFC00104, 1, 0, 1);
      for (int i = 0; i < 5; i++)
         step("stall", 0, (i % 2 == 0) ? 1'b0 : 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0,
              1, 32'hDEADBEEC, 32'hBFC00104, 1, 0, 1);
      step("stall_rd", 0, 1, 1, 1, 32'h00000000, 32'hBFC00200, 1, 0, 0);
      step("stall_nx", 0, 1, 1, 0, 32'h0, 32'hBFC00204, 1, 0, 0);

      // Redirect to the top word, then sequential wrap to zero does not halt.
      step("wrap_br", 0, 1, 1, 1, 32'hFFFFFFFC, 32'hBFC00208, 1, 0, 1);
      step("wrap_rd", 0, 1, 1, 0, 32'h0, 32'hFFFFFFFC, 1, 0, 0);
      step("wrap_0", 0, 1, 1, 0, 32'h0, 32'h00000000, 1, 0, 0);
      step("wrap_4", 0, 1, 1, 0, 32'h0, 32'h00000004, 1, 0, 0);

      // Misaligned redirect target.
      step("mis_br", 0, 1, 1, 1, 32'hBFC00102, 32'h00000008, 1, 0, 1);
      step("mis_rd", 0, 1, 1, 0, 32'h0, 32'hBFC00102, 0, 1, 0);
      step("mis_hold", 0, 1, 1, 1, 32'hBFC00300, 32'hBFC00102, 0, 1, 0);
      step("mis_rst", 1, 1, 1, 0, 32'h0, 32'hBFC00000, 1, 0, 0);

      // Halt on redirect to zero; later branches are ignored.
      step("halt_br", 0, 1, 1, 1, 32'h00000000, 32'hBFC00004, 1, 0, 1);
      step("halt_rd", 0, 1, 1, 0, 32'h0, 32'h00000000, 0, 0, 0);
      step("halt_h1", 0, 1, 1, 1, 32'hBFC00100, 32'h00000000, 0, 0, 0);
      step("halt_h2", 0, 1, 1, 1, 32'hBFC00100, 32'h00000000, 0, 0, 0);
      step("halt_rst", 1, 0, 0, 0, 32'h0, 32'hBFC00000, 1, 0, 0);

      // Reset in DELAY discards the held target.
      step("rdel_br", 0, 1, 1, 1, 32'hBFC00100, 32'hBFC00004, 1, 0, 1);
      step("rdel_rst", 1, 1, 1, 0, 32'h0, 32'hBFC00000, 1, 0, 0);
      step("rdel_nx", 0, 1, 1, 0, 32'h0, 32'hBFC00004, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
